// File: rtl/regfile_dump_controller.sv
// Debug dump sequencer: freezes the pipeline and streams the register
// file out through the UART as a header byte followed by 4 bytes per register.
module regfile_dump_controller #(
  parameter int          NUM_REGS    = 32,
  parameter int          SEL_W       = 5,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dump_start,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [31:0]      reg_data,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_done,
  output logic             pipeline_hold,
  output logic             busy,
  output logic             dump_done
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    HDR,
    HDR_WAIT,
    LOAD,
    SEND,
    WAIT,
    FINISH
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] shift_q;
  logic [1:0]  byte_cnt;
  logic        last_byte;
  logic        last_reg;

  assign last_byte = (byte_cnt == 2'd3);
  assign last_reg  = (reg_sel == LAST_SEL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (dump_start) state_nxt = HOLD;
      HOLD:     state_nxt = HDR;
      HDR:      state_nxt = HDR_WAIT;
      HDR_WAIT: if (tx_done) state_nxt = LOAD;
      LOAD:     state_nxt = SEND;
      SEND:     state_nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (last_byte && last_reg) begin
            state_nxt = FINISH;
          end else if (last_byte) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_sel  <= '0;
      shift_q  <= '0;
      byte_cnt <= '0;
    end else begin
      if (state == IDLE && dump_start) begin
        reg_sel <= '0;
      end
      if (state == LOAD) begin
        shift_q  <= reg_data;
        byte_cnt <= '0;
      end
      if (state == WAIT && tx_done) begin
        shift_q  <= shift_q >> 8;
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte && !last_reg) begin
          reg_sel <= reg_sel + SEL_W'(1);
        end
      end
    end
  end

  // Outputs decode straight from state so a reset clears them at once.
  always_comb begin
    tx_start      = 1'b0;
    tx_data       = 8'h00;
    pipeline_hold = (state != IDLE);
    busy          = (state != IDLE);
    dump_done     = (state == FINISH);
    unique case (1'b1)
      (state == HDR): begin
        tx_start = 1'b1;
        tx_data  = HEADER_BYTE;
      end
      (state == SEND): begin
        tx_start = 1'b1;
        tx_data  = shift_q[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_controller.sv
// Directed bench for regfile_dump_controller with a UART responder
// and a byte collector.
module tb_regfile_dump_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dump_start = 1'b0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        pipeline_hold;
  logic        busy;
  logic        dump_done;

  logic        spur = 1'b0;
  logic        uart_done = 1'b0;
  int          uart_delay = 10;
  int          cd = 0;

  int          checks = 0;
  int          errors = 0;
  int          dump_cnt = 0;
  int          hold_viol = 0;
  logic        last_done = 1'b0;

  logic [31:0] rf [32];
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];

  assign tx_done  = uart_done | spur;
  assign reg_data = rf[reg_sel];

  always #5 clock = ~clock;

  regfile_dump_controller dut (
    .clock         (clock),
    .reset         (reset),
    .dump_start    (dump_start),
    .reg_sel       (reg_sel),
    .reg_data      (reg_data),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_done       (tx_done),
    .pipeline_hold (pipeline_hold),
    .busy          (busy),
    .dump_done     (dump_done)
  );

  // UART: tx_done pulses uart_delay clocks after the tx_start cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cd        <= 0;
      uart_done <= 1'b0;
    end else begin
      uart_done <= 1'b0;
      if (tx_start) begin
        if (uart_delay == 1) uart_done <= 1'b1;
        else cd <= uart_delay - 1;
      end else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) uart_done <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (tx_start) got.push_back(tx_data);
      if (dump_done) dump_cnt++;
      if (last_done && pipeline_hold) hold_viol++;
      last_done = dump_done;
    end else begin
      last_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic start_dump;
    dump_start = 1'b1;
    tick;
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (dump_done !== 1'b1 && n < 3000) begin
      tick;
      n++;
    end
    chk(tag, dump_done, 1);
    tick;
  endtask

  task automatic build_exp;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(rf[r][8*b +: 8]);
  endtask

  task automatic check_frame(input string tag, input int base);
    int bad = 0;
    for (int i = 0; i < 129; i++)
      if (got.size() <= base + i || got[base+i] !== exp_q[i]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int n;
    int idle;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1]  = 32'd10;
    rf[3]  = 32'd15;
    rf[5]  = 32'hFFFF_FFFB;
    rf[6]  = 32'd12;
    rf[15] = 32'd11111;
    build_exp();

    tick;
    tick;
    chk("rst_reg_sel", reg_sel, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_hold", pipeline_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", dump_done, 0);
    reset = 1'b0;
    tick;

    // basic dump, 10-clock UART
    got.delete();
    start_dump();
    chk("hold_latency", pipeline_hold, 1);
    chk("busy_latency", busy, 1);
    wait_done("basic_done");
    repeat (3) tick;
    chk("basic_len", got.size(), 129);
    chk("basic_hdr", got[0], 8'hA5);
    chk("basic_r0", {got[4], got[3], got[2], got[1]}, 0);
    chk("basic_r1", {got[8], got[7], got[6], got[5]}, 32'h0000_000A);
    chk("basic_r5", {got[24], got[23], got[22], got[21]}, 32'hFFFF_FFFB);
    chk("basic_r15_b0", got[61], 8'h67);
    chk("basic_r15_b1", got[62], 8'h2B);
    chk("basic_r15_hi", {got[64], got[63]}, 0);
    check_frame("basic_frame", 0);
    chk("basic_done_cnt", dump_cnt, 1);
    chk("basic_hold_drop", hold_viol, 0);

    // zero-wait UART
    uart_delay = 1;
    got.delete();
    start_dump();
    chk("zw_hold_no_tx", tx_start, 0);
    tick;
    chk("zw_hdr_start", tx_start, 1);
    chk("zw_hdr_data", tx_data, 8'hA5);
    wait_done("zw_done");
    repeat (3) tick;
    chk("zw_len", got.size(), 129);
    check_frame("zw_frame", 0);
    chk("zw_done_cnt", dump_cnt, 2);

    // spurious tx_done in IDLE and coincident with tx_start
    uart_delay = 10;
    got.delete();
    spur = 1'b1;
    tick;
    spur = 1'b0;
    tick;
    chk("spur_idle_busy", busy, 0);
    start_dump();
    tick;
    chk("spur_hdr_start", tx_start, 1);
    spur = 1'b1;
    tick;
    spur = 1'b0;
    n = 0;
    while (!(tx_start === 1'b1 && got.size() >= 7) && n < 500) begin
      tick;
      n++;
    end
    chk("spur_send_seen", tx_start, 1);
    spur = 1'b1;
    tick;
    spur = 1'b0;
    wait_done("spur_done");
    repeat (3) tick;
    chk("spur_len", got.size(), 129);
    check_frame("spur_frame", 0);

    // dump_start while busy
    got.delete();
    start_dump();
    n = 0;
    while (reg_sel !== 5'd7 && n < 1000) begin
      tick;
      n++;
    end
    chk("busy_at_r7", reg_sel, 7);
    dump_start = 1'b1;
    tick;
    dump_start = 1'b0;
    chk("busy_still", busy, 1);
    wait_done("busy_done");
    repeat (200) tick;
    chk("busy_len", got.size(), 129);
    chk("busy_idle", busy, 0);
    chk("busy_done_cnt", dump_cnt, 4);
    check_frame("busy_frame", 0);

    // reset during WAIT of register 12, byte 2
    got.delete();
    start_dump();
    n = 0;
    while (!(got.size() == 52 && tx_start === 1'b0) && n < 2000) begin
      tick;
      n++;
    end
    chk("mid_in_wait", got.size(), 52);
    chk("mid_sel", reg_sel, 12);
    reset = 1'b1;
    #1;
    chk("mid_tx_start", tx_start, 0);
    chk("mid_busy", busy, 0);
    chk("mid_hold", pipeline_hold, 0);
    chk("mid_reg_sel", reg_sel, 0);
    chk("mid_done", dump_done, 0);
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("mid_no_done", dump_cnt, 4);
    got.delete();
    start_dump();
    wait_done("mid_redump_done");
    repeat (3) tick;
    chk("mid_len", got.size(), 129);
    chk("mid_hdr", got[0], 8'hA5);
    check_frame("mid_frame", 0);
    chk("mid_done_cnt", dump_cnt, 5);

    // back-to-back with dump_start held high
    got.delete();
    dump_start = 1'b1;
    n = 0;
    while (dump_done !== 1'b1 && n < 3000) begin
      tick;
      n++;
    end
    chk("b2b_first", dump_done, 1);
    tick;
    idle = 0;
    n = 0;
    while (dump_done !== 1'b1 && n < 3000) begin
      if (busy === 1'b0) idle++;
      tick;
      n++;
    end
    chk("b2b_second", dump_done, 1);
    dump_start = 1'b0;
    repeat (4) tick;
    chk("b2b_idle", idle, 1);
    chk("b2b_len", got.size(), 258);
    chk("b2b_done_cnt", dump_cnt, 7);
    check_frame("b2b_frame0", 0);
    check_frame("b2b_frame1", 129);
    chk("b2b_hold_drop", hold_viol, 0);
    chk("b2b_end_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_controller.md
Name: regfile_dump_controller

Overview:
- Sequences a debug dump of the 32-entry register file out through the UART transmitter.
- On a dump request it freezes the pipeline and walks register indices 0..NUM_REGS-1 on an external read-select mux.
- For each register it captures the 32-bit value and streams it as 4 bytes, LSB first, after a single header byte.
- Sits between the register file debug outputs, the pipeline stall logic and the UART TX module.

Parameters:
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1).
- SEL_W, 5, width of reg_sel; must satisfy 2**SEL_W >= NUM_REGS.
- HEADER_BYTE, 8'hA5, frame marker sent before register 0.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- dump_start  input  1  dump request; sampled only in IDLE.
- reg_sel  output  SEL_W  register index driven to the external 32:1 mux.
- reg_data  input  32  mux output; valid combinationally for the current reg_sel.
- tx_data  output  8  byte presented to the UART TX.
- tx_start  output  1  one-cycle pulse; the UART latches tx_data on this pulse.
- tx_done  input  1  one-cycle pulse from the UART when a byte has finished shifting.
- pipeline_hold  output  1  high for the whole dump; freezes the pipeline so the snapshot is consistent.
- busy  output  1  high in every state except IDLE.
- dump_done  output  1  one-cycle pulse when the final byte's tx_done is received.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, reg_sel=0, tx_data=0, tx_start=0, pipeline_hold=0, busy=0, dump_done=0, byte_cnt=0, shift register=0.
- A reset asserted mid-dump aborts the dump. No dump_done is issued. tx_start drops in the same instant.
- State machine:
  - IDLE: if dump_start=1, go to HOLD, set pipeline_hold=1 and reg_sel=0. Otherwise stay in IDLE.
  - HOLD: one settle cycle so the frozen register file and the mux output are stable. Go to HDR.
  - HDR: tx_data=HEADER_BYTE, tx_start=1 for exactly this cycle. Go to HDR_WAIT.
  - HDR_WAIT: wait for tx_done=1, then go to LOAD.
  - LOAD: shift register <= reg_data for the current reg_sel; byte_cnt=0. Go to SEND.
  - SEND: tx_data=shift[7:0], tx_start=1 for exactly this cycle. Go to WAIT.
  - WAIT: on tx_done=1, shift register >>= 8 and byte_cnt += 1.
    - byte_cnt was 3 and reg_sel==NUM_REGS-1: go to FINISH.
    - byte_cnt was 3 otherwise: reg_sel += 1, go to LOAD.
    - otherwise: go to SEND.
  - FINISH: dump_done=1 for one cycle; pipeline_hold=0 and busy=0 from the next cycle. Go to IDLE.
- Frame length: 1 + 4*NUM_REGS bytes (129 at the default).
- Byte order: per register, bits [7:0], [15:8], [23:16], [31:24].
- Latencies:
  - dump_start (IDLE) to pipeline_hold=1: 1 clock.
  - dump_start to first tx_start: 2 clocks.
  - tx_done of the last byte of a register to the next register's first tx_start: 2 clocks (via LOAD).
  - tx_done of a non-final byte to the next tx_start: 1 clock.
- tx_done is honoured only in HDR_WAIT and WAIT; in every other state it is ignored. A tx_done in the same cycle as tx_start is not counted.
- dump_start while busy=1 is ignored. A request is not queued. A dump_start held high in the cycle after FINISH starts a new dump.
- tx_start never asserts while in HDR_WAIT or WAIT. There is never more than one byte outstanding.
- reg_sel stops at NUM_REGS-1; it does not wrap during a dump. It returns to 0 only on the next dump_start or on reset.
- pipeline_hold is high from HOLD through FINISH inclusive.

Test Plan:
- Basic dump: register file holds r1=10, r3=15, r5=-5, r6=12, r15=11111, others 0. UART model returns tx_done 10 clocks after each tx_start; pulse dump_start. Required:
  - 129 bytes, beginning A5, 00 00 00 00, 0A 00 00 00.
  - r5 sent as FB FF FF FF; r15 sent as 67 2B 00 00.
  - dump_done pulses exactly once; pipeline_hold drops the cycle after it.
- Zero-wait UART: tx_done returned 1 clock after every tx_start. Required: header at cycle 2 after dump_start; no lost or duplicate bytes; byte count 129.
- Spurious handshake: tx_done pulses in IDLE, and again coincident with a tx_start. Required: both ignored; byte sequence identical to the basic dump.
- Request while busy: dump_start re-pulsed during register 7. Required: no restart and no second frame; exactly one dump_done.
- Reset mid-dump: reset asserted while in WAIT on register 12, byte 2. Required:
  - tx_start, busy and pipeline_hold are 0 immediately; reg_sel=0; no dump_done.
  - A fresh dump_start afterwards produces a full 129-byte frame starting A5.
- Back-to-back dumps: dump_start held high continuously. Required: two complete frames, two dump_done pulses, IDLE visited for exactly one cycle between them.
